audio_mix_scheduler: RTL
========================

AUDIO_MIX_SCHEDULER -- requirements
Module: audio_mix_scheduler

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4, number of mono voice requesters (legal 2..8).
REQ-002 SHALL have port clk  input  1  single clock for all logic.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port voice_data  input  16*NUM_VOICES  signed two's-complement sample per voice; voice i at bits [16i+15:16i].
REQ-005 SHALL have port voice_valid  input  NUM_VOICES  voice i offers a sample.
REQ-006 SHALL have port voice_ready  output  NUM_VOICES  scheduler accepts voice i sample this cycle.
REQ-007 SHALL have port voice_pan  input  2*NUM_VOICES  per voice: bit0 routes to left, bit1 routes to right.
REQ-008 SHALL have port master_mute  input  1  force mixed output to zero.
REQ-009 SHALL have ports to_dac_left_channel_data / to_dac_right_channel_data  output  16  mixed samples to the audio core.
REQ-010 SHALL have ports to_dac_left_channel_valid / to_dac_right_channel_valid  output  1  sample offered to the audio core.
REQ-011 SHALL have ports to_dac_left_channel_ready / to_dac_right_channel_ready  input  1  audio core accepts sample.
REQ-012 SHALL have port frame_count  output  16  number of completed stereo frames, wraps 0xFFFF->0x0000.

Function
REQ-013 SHALL implement FSM states COLLECT, SAT, OUT; COLLECT is entered on the first cycle after reset deasserts.
REQ-014 In COLLECT, SHALL step index idx from 0 to NUM_VOICES-1, one cycle per voice; voice_ready[i] SHALL be high exactly when state==COLLECT and idx==i.
REQ-015 Transfer on voice i SHALL occur when voice_valid[i] and voice_ready[i] are both high; voice_data is added (sign-extended) to the left accumulator if pan bit0 is set and to the right accumulator if pan bit1 is set.
REQ-016 A voice with voice_valid low at its slot SHALL contribute 0 and SHALL NOT be revisited in the same frame (no stall).
REQ-017 Accumulators SHALL be 16+ceil(log2(NUM_VOICES))+1 bits signed and SHALL clear at the start of every frame.
REQ-018 SAT (1 cycle) SHALL saturate each accumulator to 16 bits: greater than 32767 becomes 0x7FFF, less than -32768 becomes 0x8000; with master_mute high in SAT, both results SHALL be 0x0000.
REQ-019 In OUT, both valids SHALL assert together; each channel SHALL hold its data and valid until its own ready is high, then drop that valid; left and right may complete in any order or in the same cycle.
REQ-020 When both channels have completed, frame_count SHALL increment and the FSM SHALL return to COLLECT with idx=0 on the next cycle.
REQ-021 Latency from first COLLECT cycle to valid assertion SHALL be NUM_VOICES+1 cycles.
REQ-022 Output data SHALL be stable while the corresponding valid is high and ready is low.

Reset
REQ-023 While reset is low at a clock edge: state=COLLECT, idx=0, accumulators=0, both valids=0, both data=0x0000, frame_count=0, voice_ready=0.
REQ-024 A reset asserted mid-frame SHALL discard the partial frame; no sample already accepted SHALL be replayed.

Configuration
REQ-025 With macro AUDIO_MIX_VOLUME_EN defined, port voice_atten input 3*NUM_VOICES SHALL exist, and each voice sample SHALL be arithmetically shifted right by its 3-bit value (0..7) before accumulation.
REQ-026 Without AUDIO_MIX_VOLUME_EN, voice_atten SHALL be absent and samples SHALL be accumulated unshifted.

Verification
REQ-027 NUM_VOICES=4, all valid, data 0x0100, pan=2'b11, DAC ready held high -> left=right=0x0400, frame_count increments by 1 every 7 cycles.
REQ-028 Voices 0,1 = 0x7000, pan=2'b01, others invalid -> left=0x7FFF (saturated), right=0x0000.
REQ-029 All four voices = 0x8000, pan=2'b10 -> right=0x8000, left=0x0000.
REQ-030 Left ready high, right ready held low 10 cycles -> left valid drops after 1 cycle, right valid/data held stable 10 cycles, no voice_ready during the wait.
REQ-031 master_mute=1, voices valid with nonzero data -> every voice_ready handshake completes, both outputs 0x0000.
REQ-032 Reset pulsed during COLLECT at idx=2 -> valids low, frame_count=0, next frame starts at idx=0; with AUDIO_MIX_VOLUME_EN, atten=3 on 0x0800 yields 0x0100.

Source files
------------

// File: rtl/audio_mix_scheduler.sv
// Round-robin mono voice mixer producing saturated stereo frames for the DAC.
// Optional per-voice attenuation is enabled with macro AUDIO_MIX_VOLUME_EN.
module audio_mix_scheduler #(
  parameter int NUM_VOICES = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [16*NUM_VOICES-1:0]  voice_data,
  input  logic [NUM_VOICES-1:0]     voice_valid,
  output logic [NUM_VOICES-1:0]     voice_ready,
  input  logic [2*NUM_VOICES-1:0]   voice_pan,
`ifdef AUDIO_MIX_VOLUME_EN
  input  logic [3*NUM_VOICES-1:0]   voice_atten,
`endif
  input  logic                      master_mute,
  output logic [15:0]               to_dac_left_channel_data,
  output logic [15:0]               to_dac_right_channel_data,
  output logic                      to_dac_left_channel_valid,
  output logic                      to_dac_right_channel_valid,
  input  logic                      to_dac_left_channel_ready,
  input  logic                      to_dac_right_channel_ready,
  output logic [15:0]               frame_count
);

  localparam int IDXW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int ACCW = 16 + $clog2(NUM_VOICES) + 1;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SAT     = 2'd1,
    OUT     = 2'd2
  } state_t;

  state_t                  state_q;
  logic [IDXW-1:0]         idx_q;
  logic signed [ACCW-1:0]  acc_l_q;
  logic signed [ACCW-1:0]  acc_r_q;
  logic signed [ACCW-1:0]  acc_l_d;
  logic signed [ACCW-1:0]  acc_r_d;
  logic [15:0]             data_l_q;
  logic [15:0]             data_r_q;
  logic                    valid_l_q;
  logic                    valid_r_q;
  logic [15:0]             frame_q;
  logic signed [15:0]      samp_s;
  logic signed [ACCW-1:0]  ext_s;

  // Clamp to 16 bits: any disagreement among the bits above bit 15 means overflow.
  function automatic logic [15:0] sat16(input logic signed [ACCW-1:0] a);
    logic [ACCW-16:0] top;
    top = a[ACCW-1:15];
    if ((&top) || !(|top)) begin
      sat16 = a[15:0];
    end else if (a[ACCW-1]) begin
      sat16 = 16'h8000;
    end else begin
      sat16 = 16'h7FFF;
    end
  endfunction

  // Slot decode; held low while reset is asserted so no sample is taken then.
  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_ready[i] = reset && (state_q == COLLECT) && (idx_q == IDXW'(i));
    end
  end

  // Next accumulator values from the voice owning the current slot.
  always_comb begin
    acc_l_d = acc_l_q;
    acc_r_d = acc_r_q;
    samp_s  = 16'sd0;
    ext_s   = {ACCW{1'b0}};
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (voice_ready[i] && voice_valid[i]) begin
`ifdef AUDIO_MIX_VOLUME_EN
        samp_s = $signed(voice_data[16*i +: 16]) >>> voice_atten[3*i +: 3];
`else
        samp_s = $signed(voice_data[16*i +: 16]);
`endif
        ext_s = {{(ACCW-16){samp_s[15]}}, samp_s};
        if (voice_pan[2*i]) begin
          acc_l_d = acc_l_d + ext_s;
        end else begin
          acc_l_d = acc_l_d;
        end
        if (voice_pan[2*i+1]) begin
          acc_r_d = acc_r_d + ext_s;
        end else begin
          acc_r_d = acc_r_d;
        end
      end else begin
        acc_l_d = acc_l_d;
        acc_r_d = acc_r_d;
      end
    end
  end

  // Frame sequencer with registered DAC-side outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= COLLECT;
      idx_q     <= {IDXW{1'b0}};
      acc_l_q   <= {ACCW{1'b0}};
      acc_r_q   <= {ACCW{1'b0}};
      data_l_q  <= 16'h0000;
      data_r_q  <= 16'h0000;
      valid_l_q <= 1'b0;
      valid_r_q <= 1'b0;
      frame_q   <= 16'h0000;
    end else begin
      case (state_q)
        COLLECT: begin
          acc_l_q <= acc_l_d;
          acc_r_q <= acc_r_d;
          if (idx_q == IDXW'(NUM_VOICES - 1)) begin
            state_q <= SAT;
          end else begin
            idx_q <= idx_q + {{(IDXW-1){1'b0}}, 1'b1};
          end
        end
        SAT: begin
          data_l_q  <= master_mute ? 16'h0000 : sat16(acc_l_q);
          data_r_q  <= master_mute ? 16'h0000 : sat16(acc_r_q);
          valid_l_q <= 1'b1;
          valid_r_q <= 1'b1;
          state_q   <= OUT;
        end
        OUT: begin
          if (valid_l_q && to_dac_left_channel_ready) begin
            valid_l_q <= 1'b0;
          end
          if (valid_r_q && to_dac_right_channel_ready) begin
            valid_r_q <= 1'b0;
          end
          // Both channels drained: close the frame and start a fresh one.
          if (!valid_l_q && !valid_r_q) begin
            frame_q <= frame_q + 16'd1;
            state_q <= COLLECT;
            idx_q   <= {IDXW{1'b0}};
            acc_l_q <= {ACCW{1'b0}};
            acc_r_q <= {ACCW{1'b0}};
          end
        end
        default: begin
          state_q   <= COLLECT;
          idx_q     <= {IDXW{1'b0}};
          acc_l_q   <= {ACCW{1'b0}};
          acc_r_q   <= {ACCW{1'b0}};
          valid_l_q <= 1'b0;
          valid_r_q <= 1'b0;
        end
      endcase
    end
  end

  assign to_dac_left_channel_data   = data_l_q;
  assign to_dac_right_channel_data  = data_r_q;
  assign to_dac_left_channel_valid  = valid_l_q;
  assign to_dac_right_channel_valid = valid_r_q;
  assign frame_count                = frame_q;

endmodule
